config_chain_loader: RTL and testbench
======================================

# config_chain_loader

Transmit end of the fabric configuration shift chain. Accepts configuration words over a valid/ready stream, serializes them LSB-first onto the chain's serial data line with a qualifying shift enable, and pulses set once exactly `CHAIN_LEN` bits have been shifted. It drives the `shift_in`/`cen`/`set_in` inputs of the first tile in a chain of CLB and switch-box config tiles.

## Interface
- `WORD_W`, 32: width of input configuration words.
- `CHAIN_LEN`, 1024: total bits in the downstream chain; ≥1.
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a load; ignored while `busy`.
- `in_data`, in, `WORD_W`: configuration word, bit 0 shifted first.
- `in_valid`, in, 1: `in_data` valid.
- `in_ready`, out, 1: word accepted on cycles with `in_valid && in_ready`.
- `shift_out`, out, 1: serial bit to the chain's `shift_in`.
- `cen`, out, 1: chain shift enable; the chain samples `shift_out` on the rising edge while `cen` is high.
- `set_out`, out, 1: one-cycle set pulse to the chain's `set_in`.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: one-cycle pulse when the load completes.

## Operation
- Words per load: `NWORDS = ceil(CHAIN_LEN/WORD_W)`. Only the low `CHAIN_LEN - (NWORDS-1)*WORD_W` bits of the final word are shifted; its upper bits are discarded.
- Datapath: a shift register plus a one-word holding register.
  - An accepted word goes straight to the shifter if it is empty; otherwise it goes to holding.
  - `in_ready = loading && holding empty && words_accepted < NWORDS`.
- Back-to-back words give gap-free shifting. If the shifter empties while holding is empty, `cen` drops (bubble) until the next word arrives. The chain holds state while `cen` is low.
- Bit counter width is `$clog2(CHAIN_LEN+1)`. It counts `cen` cycles, and shifting stops when it reaches `CHAIN_LEN`.
- States:
  - IDLE: `start` → LOAD. Counters clear and `busy` rises next cycle.
  - LOAD: accept and shift. The last bit shifted → SET.
  - SET: `set_out` high one cycle → DONE.
  - DONE: `done` high one cycle, `busy` low that same cycle → IDLE.
- `start` while `busy`: ignored. `in_valid` outside LOAD: not accepted.
- Reset mid-load: all state returns to IDLE and `set_out` never pulses, so the chain's active (set) configuration is untouched. Partially shifted bits remain only in the chain's shadow registers.

## Timing
- Reset values: `in_ready`, `shift_out`, `cen`, `set_out`, `busy`, `done` all 0.
- `shift_out`, `cen`, `set_out`, and `done` are driven directly from flops.
- `start` sampled at edge 0 → `busy` and `in_ready` high in cycle 1.
- Word accepted at edge t → its bit 0 appears on `shift_out` with `cen`=1 in cycle t+1.
- Last chain bit in cycle L → `cen`=0 and `set_out`=1 in cycle L+1 → `done`=1 and `busy`=0 in cycle L+2.
- With words always valid, total load time is `CHAIN_LEN + 3` cycles after `start`.
- `shift_out` is 0 whenever `cen` is 0.

## Structure
- Package `config_pkg`:
  - state enum (IDLE, LOAD, SET, DONE);
  - helper function computing `NWORDS` and last-word bit count;
  - shared `CHAIN_LEN` localparams per tile type, e.g. switch box `(WS + WD/2)*6`.
- Sub-module `config_word_serializer`: holding register, shift register, and per-word bit count with an empty flag. The FSM and counters stay in the top module.

## Test plan
- `CHAIN_LEN`=40, `WORD_W`=32, words 0xA5A50F0F then 0x000000C3 always valid, `start` at cycle 0:
  - `cen` high cycles 2–41;
  - serial stream is 0xA5A50F0F LSB-first, then 0xC3 LSB-first;
  - `set_out` at cycle 42, `done` at cycle 43;
  - exactly 2 words accepted.
- Same configuration, second word delayed 5 cycles: `cen` low for a 5-cycle bubble after bit 31, the bit stream is unchanged, and `set_out` follows the 40th bit.
- `CHAIN_LEN`=64, `WORD_W`=32, final word 0xFFFFFFFF: all 32 bits shifted, and a third valid word is never accepted (`in_ready`=0).
- Pulse `start` during LOAD: no effect on counters or the output stream, and exactly one `set_out` occurs.
- Assert `rst` low at bit 20: all outputs 0 asynchronously, no `set_out`. A new `start` then completes a normal full load.
- Behavioural chain model (`CHAIN_LEN` flops plus set register) driven by the block: after `done`, the model's set register equals the loaded pattern for random words over 50 loads.

Source files
------------

// File: rtl/config_pkg.sv
// Shared types and sizing helpers for the configuration shift-chain loader.
package config_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SET  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Chain lengths of the tile types found on the configuration chain.
    // Switch box: each of six directions carries WS single and WD/2 double
    // track bits.
    localparam int SB_WS        = 4;
    localparam int SB_WD        = 8;
    localparam int SB_CHAIN_LEN = (SB_WS + SB_WD / 2) * 6;

    // CLB: N LUTs of K inputs, each with a flop-bypass select bit.
    localparam int CLB_K         = 4;
    localparam int CLB_N         = 4;
    localparam int CLB_CHAIN_LEN = CLB_N * ((2 ** CLB_K) + 1);

    // Words needed to cover a chain of chain_len bits.
    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits of the final word that actually reach the chain.
    function automatic int last_word_bits(input int chain_len, input int word_w);
        return chain_len - (num_words(chain_len, word_w) - 1) * word_w;
    endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Word-to-bit serializer: one-word holding register in front of an LSB-first
// shift register. Offers the next bit combinationally so the caller can
// register it onto the chain.
module config_word_serializer
    import config_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              emit_en_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              bit_vld_o,
    output logic              bit_o,
    output logic              hold_empty_o
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] REFILL_CNT = CW'(WORD_W - 1);

    logic [WORD_W-1:0] sh_q, sh_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              hold_vld_q, hold_vld_d;
    logic              sh_empty;

    assign sh_empty     = (cnt_q == '0);
    assign hold_empty_o = !hold_vld_q;

    // Next bit source priority: shifter, then holding, then the word being
    // accepted this cycle (so an empty datapath adds no latency).
    always_comb begin
        bit_o     = sh_q[0];
        bit_vld_o = 1'b0;
        if (sh_empty) begin
            bit_o = hold_vld_q ? hold_q[0] : word_i[0];
        end
        bit_vld_o = emit_en_i && (!sh_empty || hold_vld_q || push_i);
    end

    // Shifter / holding next state; a word whose bit 0 is taken directly
    // leaves its remaining WORD_W-1 bits in the shifter.
    always_comb begin
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (clear_i) begin
            sh_d       = '0;
            cnt_d      = '0;
            hold_d     = '0;
            hold_vld_d = 1'b0;
        end else if (emit_en_i && !sh_empty) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q - 1'b1;
            if (push_i) begin
                hold_d     = word_i;
                hold_vld_d = 1'b1;
            end
        end else if (emit_en_i && hold_vld_q) begin
            sh_d       = hold_q >> 1;
            cnt_d      = REFILL_CNT;
            hold_vld_d = push_i;
            if (push_i) begin
                hold_d = word_i;
            end
        end else if (emit_en_i && push_i) begin
            sh_d  = word_i >> 1;
            cnt_d = REFILL_CNT;
        end else if (push_i) begin
            hold_d     = word_i;
            hold_vld_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q       <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

endmodule

// File: rtl/config_chain_loader.sv
// Transmit end of the fabric configuration chain: streams CHAIN_LEN bits
// LSB-first with a shift enable, then commits them with a one-cycle set.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting words and shifting bits onto the chain
// SET   | set_out high: chain copies shadow into active config
// DONE  | done pulse, busy already low
module config_chain_loader
    import config_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_out,
    output logic              cen,
    output logic              set_out,
    output logic              busy,
    output logic              done
);

    localparam int NWORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] NWORDS_C    = WCNT_W'(NWORDS);

    state_e            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [WCNT_W-1:0] words_q;
    logic              busy_q;
    logic              done_q;
    logic              set_q;
    logic              cen_q;
    logic              so_q;

    logic loading;
    logic push;
    logic emit_en;
    logic clear;
    logic bit_vld;
    logic ser_bit;
    logic hold_empty;

    assign loading  = (state_q == LOAD);
    assign in_ready = loading && hold_empty && (words_q < NWORDS_C);
    assign push     = in_valid && in_ready;
    // Once the counter reaches CHAIN_LEN, leftover bits of the final word
    // stay in the shifter and are dropped at the next clear.
    assign emit_en  = loading && (bit_cnt_q != CHAIN_LEN_C);
    assign clear    = (state_q == IDLE) && start;

    assign shift_out = so_q;
    assign cen       = cen_q;
    assign set_out   = set_q;
    assign busy      = busy_q;
    assign done      = done_q;

    config_word_serializer #(
        .WORD_W(WORD_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .emit_en_i   (emit_en),
        .push_i      (push),
        .word_i      (in_data),
        .bit_vld_o   (bit_vld),
        .bit_o       (ser_bit),
        .hold_empty_o(hold_empty)
    );

    // Sequencer, counters and registered chain-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            words_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            set_q     <= 1'b0;
            cen_q     <= 1'b0;
            so_q      <= 1'b0;
        end else begin
            cen_q <= bit_vld;
            so_q  <= bit_vld & ser_bit;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    set_q  <= 1'b0;
                    if (start) begin
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        words_q   <= '0;
                    end
                end
                LOAD: begin
                    if (push) begin
                        words_q <= words_q + 1'b1;
                    end
                    if (bit_vld) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    if (bit_cnt_q == CHAIN_LEN_C) begin
                        state_q <= SET;
                        set_q   <= 1'b1;
                    end
                end
                SET: begin
                    state_q <= DONE;
                    set_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    set_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: a 40-bit and a 64-bit chain
// instance, with a behavioural chain (shadow shift register + set register)
// on the 40-bit instance.
module tb_config_chain_loader;

    logic clk;
    logic rst_n;

    logic        start_a, valid_a, ready_a, so_a, cen_a, set_a, busy_a, done_a;
    logic [31:0] data_a;
    logic        start_b, valid_b, ready_b, so_b, cen_b, set_b, busy_b, done_b;
    logic [31:0] data_b;

    int checks = 0;
    int errors = 0;

    logic [39:0] chain_a;
    logic [39:0] setreg_a;

    logic [63:0] r_stream;
    int r_ncen, r_first, r_last, r_bub, r_set_cnt, r_set_rel, r_done_rel;
    int r_acc, r_so_viol, r_ready_extra;
    logic r_busy_done, r_busy1, r_ready1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    config_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut40 (
        .clk(clk), .rst(rst_n), .start(start_a), .in_data(data_a), .in_valid(valid_a),
        .in_ready(ready_a), .shift_out(so_a), .cen(cen_a), .set_out(set_a),
        .busy(busy_a), .done(done_a)
    );

    config_chain_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_dut64 (
        .clk(clk), .rst(rst_n), .start(start_b), .in_data(data_b), .in_valid(valid_b),
        .in_ready(ready_b), .shift_out(so_b), .cen(cen_b), .set_out(set_b),
        .busy(busy_b), .done(done_b)
    );

    // Downstream chain: bit shifted first ends up in chain_a[0].
    always @(posedge clk) begin
        if (cen_a) chain_a <= {so_a, chain_a[39:1]};
        if (set_a) setreg_a <= chain_a;
    end

    // One load on instance sel (0: 40-bit, 1: 64-bit). Word 0 offered from
    // cycle 0, later words from cycle t1. Cycle 0 is the start cycle.
    task automatic run_load(input int sel, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input int nsend, input int t1,
                            input int restart_rel, input int abort_rel);
        logic [31:0] words [3];
        int avail [3];
        int wi;
        logic c, so, st, d, b, rdy, vld;
        words = '{w0, w1, w2};
        avail = '{0, t1, t1};
        wi = 0;
        r_stream = '0; r_ncen = 0; r_first = -1; r_last = -1; r_bub = -1;
        r_set_cnt = 0; r_set_rel = -1; r_done_rel = -1; r_acc = 0;
        r_so_viol = 0; r_ready_extra = 0; r_busy_done = 1'b1;
        r_busy1 = 1'b0; r_ready1 = 1'b0;
        for (int rel = 0; rel < 200; rel++) begin
            @(negedge clk);
            if (rel == abort_rel) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({ready_a, so_a, cen_a, set_a, busy_a, done_a} !== 6'b0) begin
                    errors++;
                    $display("FAIL async_reset_outputs: got %b expected 000000",
                             {ready_a, so_a, cen_a, set_a, busy_a, done_a});
                end
                start_a = 1'b0;
                valid_a = 1'b0;
                return;
            end
            c   = sel != 0 ? cen_b   : cen_a;
            so  = sel != 0 ? so_b    : so_a;
            st  = sel != 0 ? set_b   : set_a;
            d   = sel != 0 ? done_b  : done_a;
            b   = sel != 0 ? busy_b  : busy_a;
            rdy = sel != 0 ? ready_b : ready_a;
            if (c) begin
                if (r_ncen < 64) r_stream[r_ncen] = so;
                r_ncen++;
                if (r_first < 0) r_first = rel;
                r_last = rel;
            end else begin
                if (so) r_so_viol++;
                if (r_first >= 0 && r_bub < 0 && r_set_cnt == 0) r_bub = rel;
            end
            if (st) begin
                r_set_cnt++;
                r_set_rel = rel;
            end
            if (d && r_done_rel < 0) begin
                r_done_rel = rel;
                r_busy_done = b;
            end
            if (rel == 1) begin
                r_busy1 = b;
                r_ready1 = rdy;
            end
            if (r_acc >= 2 && rdy) r_ready_extra++;
            st  = (rel == 0) || (rel == restart_rel);
            vld = (wi < nsend) && (rel >= avail[wi < 3 ? wi : 2]);
            if (sel != 0) begin
                start_b = st; valid_b = vld; data_b = words[wi < 3 ? wi : 2];
            end else begin
                start_a = st; valid_a = vld; data_a = words[wi < 3 ? wi : 2];
            end
            if (vld && rdy) begin
                r_acc++;
                wi++;
            end
            if (r_done_rel >= 0 && rel == r_done_rel + 2) break;
        end
        start_a = 1'b0; valid_a = 1'b0;
        start_b = 1'b0; valid_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready_a, so_a, cen_a, set_a, busy_a, done_a, ready_b, so_b, cen_b, set_b, busy_b, done_b} !== 12'b0) begin
            errors++;
            $display("FAIL reset_values: got %b expected all zero",
                     {ready_a, so_a, cen_a, set_a, busy_a, done_a, ready_b, so_b, cen_b, set_b, busy_b, done_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_load(0, 32'hA5A50F0F, 32'h000000C3, 32'h0, 2, 0, -1, -1);
        checks++; if (r_busy1 !== 1'b1 || r_ready1 !== 1'b1) begin errors++;
            $display("FAIL basic_cycle1: busy=%b ready=%b expected 1 1", r_busy1, r_ready1); end
        checks++; if (r_first !== 2 || r_last !== 41) begin errors++;
            $display("FAIL basic_cen_window: got %0d..%0d expected 2..41", r_first, r_last); end
        checks++; if (r_ncen !== 40) begin errors++;
            $display("FAIL basic_cen_count: got %0d expected 40", r_ncen); end
        checks++; if (r_stream[39:0] !== 40'hC3_A5A50F0F) begin errors++;
            $display("FAIL basic_stream: got %h expected c3a5a50f0f", r_stream[39:0]); end
        checks++; if (r_set_cnt !== 1 || r_set_rel !== 42) begin errors++;
            $display("FAIL basic_set: got %0d pulses at %0d expected 1 at 42", r_set_cnt, r_set_rel); end
        checks++; if (r_done_rel !== 43 || r_busy_done !== 1'b0) begin errors++;
            $display("FAIL basic_done: got cycle %0d busy %b expected 43 busy 0", r_done_rel, r_busy_done); end
        checks++; if (r_acc !== 2) begin errors++;
            $display("FAIL basic_accepts: got %0d expected 2", r_acc); end
        checks++; if (r_so_viol !== 0) begin errors++;
            $display("FAIL basic_so_idle: got %0d cycles with shift_out=1 and cen=0 expected 0", r_so_viol); end
        checks++; if (setreg_a !== 40'hC3_A5A50F0F) begin errors++;
            $display("FAIL basic_chain_set: got %h expected c3a5a50f0f", setreg_a); end
    endtask

    task automatic test_bubble();
        run_load(0, 32'hA5A50F0F, 32'h000000C3, 32'h0, 2, 38, -1, -1);
        checks++; if (r_bub !== 34 || r_first !== 2 || r_last !== 46) begin errors++;
            $display("FAIL bubble_window: first %0d bubble %0d last %0d expected 2 34 46", r_first, r_bub, r_last); end
        checks++; if (r_ncen !== 40 || (r_last - r_first + 1 - r_ncen) !== 5) begin errors++;
            $display("FAIL bubble_length: cen %0d gap %0d expected 40 5", r_ncen, r_last - r_first + 1 - r_ncen); end
        checks++; if (r_stream[39:0] !== 40'hC3_A5A50F0F) begin errors++;
            $display("FAIL bubble_stream: got %h expected c3a5a50f0f", r_stream[39:0]); end
        checks++; if (r_set_cnt !== 1 || r_set_rel !== 47 || r_done_rel !== 48) begin errors++;
            $display("FAIL bubble_set_done: set %0d@%0d done %0d expected 1@47 48", r_set_cnt, r_set_rel, r_done_rel); end
    endtask

    task automatic test_chain64();
        run_load(1, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF, 3, 0, -1, -1);
        checks++; if (r_ncen !== 64 || r_stream !== 64'hFFFFFFFF_12345678) begin errors++;
            $display("FAIL c64_stream: got %0d bits %h expected 64 ffffffff12345678", r_ncen, r_stream); end
        checks++; if (r_acc !== 2 || r_ready_extra !== 0) begin errors++;
            $display("FAIL c64_third_word: accepts %0d extra ready %0d expected 2 0", r_acc, r_ready_extra); end
        checks++; if (r_set_rel !== 66 || r_done_rel !== 67) begin errors++;
            $display("FAIL c64_set_done: set %0d done %0d expected 66 67", r_set_rel, r_done_rel); end
    endtask

    task automatic test_start_during_load();
        run_load(0, 32'h3C3C5AA5, 32'h0000005E, 32'h0, 2, 0, 10, -1);
        checks++; if (r_first !== 2 || r_last !== 41 || r_stream[39:0] !== 40'h5E_3C3C5AA5) begin errors++;
            $display("FAIL restart_stream: %0d..%0d %h expected 2..41 5e3c3c5aa5", r_first, r_last, r_stream[39:0]); end
        checks++; if (r_set_cnt !== 1 || r_set_rel !== 42 || r_done_rel !== 43) begin errors++;
            $display("FAIL restart_set: set %0d@%0d done %0d expected 1@42 43", r_set_cnt, r_set_rel, r_done_rel); end
    endtask

    task automatic test_reset_mid_load();
        logic [39:0] saved;
        saved = setreg_a;
        run_load(0, 32'hFFFF0000, 32'h00000011, 32'h0, 2, 0, -1, 22);
        repeat (3) @(negedge clk);
        checks++; if (r_set_cnt !== 0 || set_a !== 1'b0 || setreg_a !== saved) begin errors++;
            $display("FAIL abort_no_set: pulses %0d set reg %h expected 0 %h", r_set_cnt, setreg_a, saved); end
        rst_n = 1'b1;
        @(negedge clk);
        run_load(0, 32'h0F1E2D3C, 32'h0000004B, 32'h0, 2, 0, -1, -1);
        checks++; if (r_set_rel !== 42 || r_done_rel !== 43 || setreg_a !== 40'h4B_0F1E2D3C) begin errors++;
            $display("FAIL abort_reload: set %0d done %0d reg %h expected 42 43 4b0f1e2d3c", r_set_rel, r_done_rel, setreg_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0, w1;
        for (int n = 0; n < 50; n++) begin
            w0 = $urandom;
            w1 = $urandom;
            run_load(0, w0, w1, 32'h0, 2, 0, -1, -1);
            checks++;
            if (setreg_a !== {w1[7:0], w0} || r_set_cnt !== 1) begin
                errors++;
                $display("FAIL b2b_load%0d: got %h (%0d sets) expected %h", n, setreg_a, r_set_cnt, {w1[7:0], w0});
            end
        end
    endtask

    initial begin
        start_a = 1'b0; valid_a = 1'b0; data_a = '0;
        start_b = 1'b0; valid_b = 1'b0; data_b = '0;
        test_reset();
        test_basic();
        test_bubble();
        test_chain64();
        test_start_during_load();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
